// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed display scanner with frame-synchronous value commit
// Optional leading-zero blanking: define DISPLAY_SCAN_LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 16000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic        load_valid,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_dots,
  output logic        load_ready,
  output logic [3:0]  seg_digit,
  output logic        seg_dot,
  output logic [3:0]  dig_en_n,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   act_val_q, act_val_d;
  logic [3:0]    act_dots_q, act_dots_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dots_q, pend_dots_d;
  logic          pend_full_q, pend_full_d;
  logic          en_q;
  logic          frame_done_q, frame_done_d;
  logic          commit;
  logic [3:0]    lz_blank;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      act_val_q    <= 16'h0000;
      act_dots_q   <= 4'b0000;
      pend_val_q   <= 16'h0000;
      pend_dots_q  <= 4'b0000;
      pend_full_q  <= 1'b0;
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dots_q   <= act_dots_d;
      pend_val_q   <= pend_val_d;
      pend_dots_q  <= pend_dots_d;
      pend_full_q  <= pend_full_d;
      en_q         <= enable;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    commit       = (cnt_q == CNT_LAST) && (idx_q == 2'd3);
    cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d        = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
    state_d      = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    frame_done_d = commit;
    act_val_d    = act_val_q;
    act_dots_d   = act_dots_q;
    pend_val_d   = pend_val_q;
    pend_dots_d  = pend_dots_q;
    pend_full_d  = pend_full_q;
    // Commit uses the pre-edge pending flag, so a load landing on the commit edge waits a full frame.
    if (commit && pend_full_q) begin
      act_val_d   = pend_val_q;
      act_dots_d  = pend_dots_q;
      pend_full_d = 1'b0;
    end
    if (load_valid && !pend_full_q) begin
      pend_val_d  = load_value;
      pend_dots_d = load_dots;
      pend_full_d = 1'b1;
    end
  end

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank[0] = 1'b0;
    lz_blank[1] = (act_val_q[15:4]  == 12'h000) && !act_dots_q[1];
    lz_blank[2] = (act_val_q[15:8]  == 8'h00)   && !act_dots_q[2];
    lz_blank[3] = (act_val_q[15:12] == 4'h0)    && !act_dots_q[3];
  end
`else
  assign lz_blank = 4'b0000;
`endif

  always_comb begin
    dig_en_n = 4'b1111;
    if ((state_q == ST_SHOW) && en_q && !lz_blank[idx_q]) begin
      dig_en_n = ~(4'b0001 << idx_q);
    end
  end

  assign seg_digit  = act_val_q[{idx_q, 2'b00} +: 4];
  assign seg_dot    = act_dots_q[idx_q];
  assign load_ready = !pend_full_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl against a position-arithmetic model
module tb_display_scan_ctrl;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_value = 16'h0;
  logic [3:0]  load_dots = 4'h0;
  logic        load_ready;
  logic [3:0]  seg_digit;
  logic        seg_dot;
  logic [3:0]  dig_en_n;
  logic        frame_done;

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .load_valid(load_valid),
    .load_value(load_value), .load_dots(load_dots), .load_ready(load_ready),
    .seg_digit(seg_digit), .seg_dot(seg_dot), .dig_en_n(dig_en_n), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Model: edges since reset, shown value/dots, one-deep pending slot, last sampled enable.
  int          m_n;
  logic [15:0] m_act, m_pval;
  logic [3:0]  m_adots, m_pdots;
  logic        m_full, m_en;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h at n=%0d", tag, got, exp, m_n);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_act = 16'h0; m_adots = 4'h0; m_pval = 16'h0; m_pdots = 4'h0;
    m_full = 1'b0; m_en = 1'b0;
  endtask

  function automatic logic [3:0] exp_dig_en();
    int slot_pos = m_n % SD;
    int digit = (m_n / SD) % 4;
    logic [3:0] r = 4'hF;
    if (slot_pos < BC || !m_en) return 4'hF;
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
    if (digit > 0 && (m_act >> (4 * digit)) == 16'h0 && !m_adots[digit]) return 4'hF;
`endif
    r[digit] = 1'b0;
    return r;
  endfunction

  task automatic check_all();
    int digit = (m_n / SD) % 4;
    chk("dig_en_n", 16'(dig_en_n), 16'(exp_dig_en()));
    chk("seg_digit", 16'(seg_digit), (m_act >> (4 * digit)) & 16'hF);
    chk("seg_dot", 16'(seg_dot), 16'(m_adots[digit]));
    chk("load_ready", 16'(load_ready), 16'(!m_full));
    chk("frame_done", 16'(frame_done), 16'(m_n > 0 && (m_n % FRAME) == 0));
  endtask

  task automatic tick();
    logic rdy;
    @(posedge CLK);
    rdy = !m_full;
    if ((m_n % FRAME) == FRAME - 1 && m_full) begin
      m_act = m_pval; m_adots = m_pdots; m_full = 1'b0;
    end
    if (load_valid && rdy) begin
      m_pval = load_value; m_pdots = load_dots; m_full = 1'b1;
    end
    m_en = enable;
    m_n++;
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] d);
    logic rdy;
    load_valid = 1'b1; load_value = v; load_dots = d;
    for (int i = 0; i < 3 * FRAME; i++) begin
      rdy = !m_full;
      tick();
      if (rdy) break;
    end
    load_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    RST_N = 1'b1;
    enable = 1'b1;

    // Free run with zero value: frame_done cadence and slot blanking.
    run(2 * FRAME);

    // Directed load shown from the next frame.
    offer(16'h1234, 4'b0001);
    run(2 * FRAME);

    // Back-to-back held offers: second one waits for the first commit.
    load_valid = 1'b1; load_value = 16'hAAAA; load_dots = 4'h0;
    run(3);
    load_value = 16'hBBBB;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (m_full && m_pval == 16'hBBBB) break;
    end
    load_valid = 1'b0;
    run(2 * FRAME);

    // Display disabled for a frame while a load proceeds.
    enable = 1'b0;
    offer(16'h5678, 4'b1010);
    run(FRAME);
    enable = 1'b1;
    run(FRAME);

    // Leading-zero patterns.
    offer(16'h0050, 4'b0000);
    run(2 * FRAME);
    offer(16'h0000, 4'b0000);
    run(2 * FRAME);
    offer(16'h0300, 4'b1000);
    run(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_value = 16'($urandom);
      load_dots  = 4'($urandom);
      enable     = ($urandom_range(0, 7) != 0);
      tick();
    end
    load_valid = 1'b0;
    enable = 1'b1;

    // Reset mid-SHOW with a value pending.
    offer(16'h9ABC, 4'hF);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_full && (m_n % SD) >= BC) break;
      tick();
    end
    chk("pending_before_reset", 16'(m_full), 16'h1);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    @(negedge CLK);
    RST_N = 1'b1;
    run(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 16000: CLK cycles per digit slot; legal range is SCAN_DIV >= 2.
REQ-002 Parameter BLANK_CYCLES, default 64: dead-time cycles at the start of each slot; legal range is 1 <= BLANK_CYCLES < SCAN_DIV.
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  asynchronous reset, active-low.
REQ-005 enable  input  1  1 = display lit; 0 = all digits forced off while scanning continues.
REQ-006 load_valid  input  1  a new display value is offered.
REQ-007 load_value  input  16  four hex nibbles; digit i = load_value[4i+3:4i], digit 0 least significant.
REQ-008 load_dots  input  4  decimal point per digit; bit i belongs to digit i.
REQ-009 load_ready  output  1  block can accept a value this cycle.
REQ-010 seg_digit  output  4  nibble for the segment decoder.
REQ-011 seg_dot  output  1  dot for the segment decoder; 1 = dot lit.
REQ-012 dig_en_n  output  4  active-low digit enables; bit i drives digit i.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-014 A slot counter cnt SHALL run 0..SCAN_DIV-1 and wrap; the digit index idx SHALL advance 0->1->2->3->0 on each wrap.
REQ-015 The FSM SHALL be in state BLANK while cnt < BLANK_CYCLES and in state SHOW otherwise; there are no other states.
REQ-016 In BLANK, dig_en_n SHALL be 4'b1111.
REQ-017 In SHOW with enable=1, dig_en_n SHALL have only bit idx low.
REQ-018 In every state, seg_digit and seg_dot SHALL present active nibble idx and active dot idx.
REQ-019 All outputs SHALL be decoded from registered state only; there SHALL be no combinational path from any input to any output.
REQ-020 A transfer SHALL occur on a rising edge with load_valid=1 and load_ready=1.
  - The transfer writes a pending register.
  - load_ready SHALL be 0 from the next cycle on.
REQ-021 Commit point: the cycle where cnt = SCAN_DIV-1 and idx = 3.
  - If the pending register is full, its contents SHALL become the active value/dots on that edge.
  - The pending register SHALL then empty, and load_ready SHALL return to 1 on the following cycle.
REQ-022 A transfer on the commit-point cycle (pending empty) SHALL be held and committed at the next commit point, not bypassed.
REQ-023 While load_ready = 0, load_valid SHALL be ignored.
REQ-024 The active value SHALL only change at a commit point, so no frame ever displays mixed values.
REQ-025 frame_done SHALL be high during the cycle following each commit point, whether or not a commit happened; the frame period is 4*SCAN_DIV cycles.
REQ-026 A change on enable SHALL take effect on dig_en_n one cycle after it is sampled; cnt, idx, frame_done and the handshake SHALL be unaffected by enable.

Reset
REQ-027 While RST_N = 0, the outputs and state SHALL take these values immediately, independent of CLK:
  - cnt = 0, idx = 0, state = BLANK
  - active value = 16'h0000, active dots = 4'b0000
  - pending register empty
  - dig_en_n = 4'b1111, load_ready = 1, frame_done = 0, seg_digit = 0, seg_dot = 0
REQ-028 A reset asserted mid-slot or while a value is pending SHALL discard that pending value.
REQ-029 After RST_N rises, the first slot SHALL start at cnt = 0, idx = 0.

Configuration
REQ-030 The macro DISPLAY_SCAN_LEADING_ZERO_BLANK_EN controls leading-zero blanking.
  - Defined: dig_en_n bit i SHALL stay 1 for every digit i > 0 whose nibble and all more-significant nibbles are zero and whose dot is 0. Digit 0 is never blanked.
  - Undefined: all four digits SHALL scan unconditionally, with no blanking logic synthesized.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-031 Free run, enable=1, value 0 -> frame_done every 32 cycles; per slot dig_en_n is 1111 for 2 cycles, then the idx bit is low for 6 cycles.
REQ-032 Load 16'h1234 with dots 4'b0001 -> load_ready=0 until the first commit point; next frame shows:
  - digit 0: seg_digit=4, seg_dot=1, dig_en_n=1110
  - digit 3: seg_digit=1, dig_en_n=0111
REQ-033 Hold load_valid with 16'hAAAA and then 16'hBBBB back-to-back -> only 16'hAAAA accepted; 16'hBBBB accepted in the cycle after the commit and shown one frame later.
REQ-034 enable=0 for one full frame -> dig_en_n stays 1111; frame_done pulses unchanged; a load still completes.
REQ-035 Drop RST_N mid-SHOW with a value pending -> dig_en_n=1111 and load_ready=1 without a clock edge; after release, the old active value is gone and the display shows 0.
REQ-036 With the macro defined, load 16'h0050 -> digits 3 and 2 stay off, digits 1 and 0 scan; load 16'h0000 -> only digit 0 lit.
